// File: rtl/clock_divider_bank.sv
// clock_divider_bank
// Multi-channel programmable clock divider. Each channel counts enabled
// system-clock edges modulo its divisor D and produces a registered divided
// clock (low for D-H cycles, high for H cycles) plus a one-cycle tick at the
// start of every period. New settings are held in a shadow register and move
// into the active set only on a period boundary, so no runt pulse can occur.
//
// Ports:
//   i_SYS_CLOCK     system clock, all logic on the rising edge
//   i_RESET         asynchronous active-high reset
//   i_ENABLE        per-channel run enable
//   i_LOAD          one-cycle strobe writing the shadow settings of one channel
//   i_LOAD_CHANNEL  channel targeted by i_LOAD (out-of-range index is ignored)
//   i_DIVISOR       new period in cycles (clamped to >= 2)
//   i_HIGH_COUNT    new high time in cycles (clamped to [1, D-1])
//   o_CLOCK         registered divided clock per channel
//   o_TICK          registered period-start pulse per channel
//   o_PENDING       per channel: a shadow update awaits a period boundary
module clock_divider_bank #(
  parameter int CHANNELS      = 4,
  parameter int WIDTH         = 16,
  parameter int RESET_DIVISOR = 2,
  parameter int RESET_HIGH    = 1,
  parameter int IDX_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                i_SYS_CLOCK,
  input  logic                i_RESET,
  input  logic [CHANNELS-1:0] i_ENABLE,
  input  logic                i_LOAD,
  input  logic [IDX_W-1:0]    i_LOAD_CHANNEL,
  input  logic [WIDTH-1:0]    i_DIVISOR,
  input  logic [WIDTH-1:0]    i_HIGH_COUNT,
  output logic [CHANNELS-1:0] o_CLOCK,
  output logic [CHANNELS-1:0] o_TICK,
  output logic [CHANNELS-1:0] o_PENDING
);

  localparam logic [WIDTH-1:0] RST_D = WIDTH'(RESET_DIVISOR);
  localparam logic [WIDTH-1:0] RST_H = WIDTH'(RESET_HIGH);

  // Divisors below 2 cannot produce a toggling output; force them to 2.
  function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    if (d < WIDTH'(2)) begin
      r = WIDTH'(2);
    end else begin
      r = d;
    end
    return r;
  endfunction

  // High time limited to [1, d_c-1] so the low phase D-H is at least one cycle.
  function automatic logic [WIDTH-1:0] clamp_high(input logic [WIDTH-1:0] d_c,
                                                   input logic [WIDTH-1:0] h);
    logic [WIDTH-1:0] max_h;
    logic [WIDTH-1:0] r;
    max_h = d_c - WIDTH'(1);
    if (h == WIDTH'(0)) begin
      r = WIDTH'(1);
    end else if (h > max_h) begin
      r = max_h;
    end else begin
      r = h;
    end
    return r;
  endfunction

  logic [WIDTH-1:0] new_d;
  logic [WIDTH-1:0] new_h;

  // Clamped load values, shared by all channels.
  always_comb begin
    new_d = clamp_div(i_DIVISOR);
    new_h = clamp_high(new_d, i_HIGH_COUNT);
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WIDTH-1:0] cnt_r, act_d_r, act_h_r, sh_d_r, sh_h_r;
    logic             pend_r, clk_r, tick_r;
    logic [WIDTH-1:0] nxt_cnt, nxt_act_d, nxt_act_h, nxt_sh_d, nxt_sh_h;
    logic             nxt_pend, nxt_clk, nxt_tick;
    logic             load_hit, wrap;

    // Next-state logic for one channel: count, shadow handling and outputs.
    always_comb begin
      load_hit  = i_LOAD && (i_LOAD_CHANNEL == IDX_W'(c));
      wrap      = (cnt_r == (act_d_r - WIDTH'(1)));
      nxt_cnt   = cnt_r;
      nxt_act_d = act_d_r;
      nxt_act_h = act_h_r;
      nxt_sh_d  = sh_d_r;
      nxt_sh_h  = sh_h_r;
      nxt_pend  = pend_r;
      nxt_clk   = 1'b0;
      nxt_tick  = 1'b0;
      if (!i_ENABLE[c]) begin
        // Idle channel: settings take effect at once, outputs held low.
        nxt_cnt  = {WIDTH{1'b0}};
        nxt_pend = 1'b0;
        if (load_hit) begin
          nxt_act_d = new_d;
          nxt_act_h = new_h;
          nxt_sh_d  = new_d;
          nxt_sh_h  = new_h;
        end else begin
          nxt_act_d = sh_d_r;
          nxt_act_h = sh_h_r;
        end
      end else begin
        if (load_hit) begin
          nxt_sh_d = new_d;
          nxt_sh_h = new_h;
        end else begin
          nxt_sh_d = sh_d_r;
          nxt_sh_h = sh_h_r;
        end
        if (wrap) begin
          // Period boundary: the latest settings (including a load on this
          // very edge) govern the period that starts here.
          nxt_cnt   = {WIDTH{1'b0}};
          nxt_act_d = nxt_sh_d;
          nxt_act_h = nxt_sh_h;
          nxt_pend  = 1'b0;
        end else begin
          nxt_cnt  = cnt_r + WIDTH'(1);
          nxt_pend = pend_r | load_hit;
        end
        nxt_clk  = (nxt_cnt >= (nxt_act_d - nxt_act_h));
        nxt_tick = (nxt_cnt == {WIDTH{1'b0}});
      end
    end

    // Channel state and registered outputs.
    always_ff @(posedge i_SYS_CLOCK or posedge i_RESET) begin
      if (i_RESET) begin
        cnt_r   <= {WIDTH{1'b0}};
        act_d_r <= RST_D;
        act_h_r <= RST_H;
        sh_d_r  <= RST_D;
        sh_h_r  <= RST_H;
        pend_r  <= 1'b0;
        clk_r   <= 1'b0;
        tick_r  <= 1'b0;
      end else begin
        cnt_r   <= nxt_cnt;
        act_d_r <= nxt_act_d;
        act_h_r <= nxt_act_h;
        sh_d_r  <= nxt_sh_d;
        sh_h_r  <= nxt_sh_h;
        pend_r  <= nxt_pend;
        clk_r   <= nxt_clk;
        tick_r  <= nxt_tick;
      end
    end

    assign o_CLOCK[c]   = clk_r;
    assign o_TICK[c]    = tick_r;
    assign o_PENDING[c] = pend_r;
  end

endmodule
